// File: rtl/hpi_target_if.sv
// HPI bus strobes, register select and interrupt between the host-side bridge and the target.
// HPI_DATA is a plain inout port on the target so the tristate net resolves at the top level.
interface hpi_target_if;
  logic [1:0] HPI_ADDR;
  logic       HPI_RD_N;
  logic       HPI_WR_N;
  logic       HPI_CS_N;
  logic       HPI_RST_N;
  logic       HPI_INT;

  modport master (
    output HPI_ADDR, HPI_RD_N, HPI_WR_N, HPI_CS_N, HPI_RST_N,
    input  HPI_INT
  );

  modport slave (
    input  HPI_ADDR, HPI_RD_N, HPI_WR_N, HPI_CS_N, HPI_RST_N,
    output HPI_INT
  );
endinterface

// File: rtl/hpi_target.sv
// HPI responder: word memory behind an auto-incrementing byte pointer, plus host/local mailboxes.
// Read data drives 3 Clk after strobe assertion; side effects commit on the strobe-release exit cycle.
module hpi_target #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  hpi_target_if.slave   hpi,
  inout  wire  [15:0]   HPI_DATA,
  output logic [15:0]   mbx_in_data,
  output logic          mbx_in_valid,
  input  logic          mbx_in_ack,
  input  logic [15:0]   mbx_out_data,
  input  logic          mbx_out_wr,
  output logic          mbx_out_busy,
  input  logic [AW-1:0] loc_addr,
  output logic [15:0]   loc_rdata
);

  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_MBX  = 2'd1;
  localparam logic [1:0] SEL_ADDR = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WAIT} state_t;

  state_t      state, nxt;
  logic [1:0]  rd_n_q, wr_n_q, cs_n_q, rst_n_q;
  logic [1:0]  addr_q0, addr_q1;
  logic        rd_n_s, wr_n_s, cs_n_s, srst;
  logic        load_rd, latch_sel, rd_commit, wr_commit;
  logic [1:0]  sel;
  logic [15:0] rd_reg, wr_dat, ptr;
  logic [15:0] in_mbx, out_mbx;
  logic        in_full, out_full, overrun;
  logic [15:0] mem [DEPTH];

  // Two-flop synchronizers; strobes idle high so reset leaves them deasserted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_n_q  <= 2'b11;
      wr_n_q  <= 2'b11;
      cs_n_q  <= 2'b11;
      rst_n_q <= 2'b11;
      addr_q0 <= 2'd0;
      addr_q1 <= 2'd0;
    end else begin
      rd_n_q  <= {rd_n_q[0], hpi.HPI_RD_N};
      wr_n_q  <= {wr_n_q[0], hpi.HPI_WR_N};
      cs_n_q  <= {cs_n_q[0], hpi.HPI_CS_N};
      rst_n_q <= {rst_n_q[0], hpi.HPI_RST_N};
      addr_q0 <= hpi.HPI_ADDR;
      addr_q1 <= addr_q0;
    end
  end

  assign rd_n_s = rd_n_q[1];
  assign wr_n_s = wr_n_q[1];
  assign cs_n_s = cs_n_q[1];
  assign srst   = ~rst_n_q[1];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    load_rd   = 1'b0;
    latch_sel = 1'b0;
    rd_commit = 1'b0;
    wr_commit = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n_s) begin
          if (!rd_n_s && wr_n_s) begin
            nxt     = READ;
            load_rd = 1'b1;
          end else if (rd_n_s && !wr_n_s) begin
            nxt       = WRITE;
            latch_sel = 1'b1;
          end else begin
            nxt = WAIT;
          end
        end
      end
      READ: begin
        if (cs_n_s || rd_n_s) begin
          nxt       = IDLE;
          rd_commit = 1'b1;
        end
      end
      WRITE: begin
        if (cs_n_s || wr_n_s) begin
          nxt       = IDLE;
          wr_commit = 1'b1;
        end
      end
      WAIT: begin
        if (cs_n_s || (rd_n_s && wr_n_s)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Soft reset aborts any access without committing it.
    if (srst) begin
      nxt       = IDLE;
      load_rd   = 1'b0;
      latch_sel = 1'b0;
      rd_commit = 1'b0;
      wr_commit = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel      <= SEL_DATA;
      rd_reg   <= 16'h0000;
      wr_dat   <= 16'h0000;
      ptr      <= 16'h0000;
      in_mbx   <= 16'h0000;
      in_full  <= 1'b0;
      overrun  <= 1'b0;
      out_mbx  <= 16'h0000;
      out_full <= 1'b0;
    end else if (srst) begin
      sel      <= SEL_DATA;
      rd_reg   <= 16'h0000;
      wr_dat   <= 16'h0000;
      ptr      <= 16'h0000;
      in_mbx   <= 16'h0000;
      in_full  <= 1'b0;
      overrun  <= 1'b0;
      out_mbx  <= 16'h0000;
      out_full <= 1'b0;
    end else begin
      if (load_rd || latch_sel) sel <= addr_q1;
      if (load_rd) begin
        case (addr_q1)
          SEL_DATA: rd_reg <= mem[ptr[AW:1]];
          SEL_MBX:  rd_reg <= out_mbx;
          SEL_ADDR: rd_reg <= ptr;
          default:  rd_reg <= {13'b0, overrun, in_full, out_full};
        endcase
      end
      if (state == WRITE) wr_dat <= HPI_DATA;

      if ((rd_commit || wr_commit) && sel == SEL_DATA) ptr <= ptr + 16'd2;
      else if (wr_commit && sel == SEL_ADDR)           ptr <= wr_dat;

      // A host mailbox write on the same cycle as a local ack keeps the mailbox full.
      if (wr_commit && sel == SEL_MBX) begin
        in_mbx  <= wr_dat;
        in_full <= 1'b1;
        if (in_full) overrun <= 1'b1;
      end else if (mbx_in_ack && in_full) begin
        in_full <= 1'b0;
      end
      if (rd_commit && sel == SEL_STAT) overrun <= 1'b0;

      if (rd_commit && sel == SEL_MBX) begin
        out_full <= 1'b0;
      end else if (mbx_out_wr && !out_full) begin
        out_mbx  <= mbx_out_data;
        out_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_commit && sel == SEL_DATA) mem[ptr[AW:1]] <= wr_dat;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)     loc_rdata <= 16'h0000;
    else if (srst) loc_rdata <= 16'h0000;
    else           loc_rdata <= mem[loc_addr];
  end

  assign HPI_DATA     = (state == READ && !Reset) ? rd_reg : 16'hzzzz;
  assign hpi.HPI_INT  = out_full;
  assign mbx_in_valid = in_full;
  assign mbx_in_data  = in_mbx;
  assign mbx_out_busy = out_full;

endmodule

// File: tb/tb_hpi_target.sv
// Bench for hpi_target: directed steps then random host/local traffic against a register-level model.
// The data bus is pulled up, so a released HPI_DATA reads as 16'hFFFF.
module tb_hpi_target;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  hpi_target_if hif ();
  wire  [15:0]   hpi_data;
  logic          host_en;
  logic [15:0]   host_dat;
  logic [15:0]   mbx_in_data;
  logic          mbx_in_valid;
  logic          mbx_in_ack;
  logic [15:0]   mbx_out_data;
  logic          mbx_out_wr;
  logic          mbx_out_busy;
  logic [AW-1:0] loc_addr;
  logic [15:0]   loc_rdata;

  assign hpi_data = host_en ? host_dat : 16'hzzzz;
  pullup (hpi_data);

  hpi_target #(.DEPTH(DEPTH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hpi          (hif),
    .HPI_DATA     (hpi_data),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_busy (mbx_out_busy),
    .loc_addr     (loc_addr),
    .loc_rdata    (loc_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: host-visible registers and memory contents.
  logic [15:0] mem_m [DEPTH];
  bit          mem_v [DEPTH];
  logic [15:0] ptr_m, in_mbx_m, out_mbx_m;
  bit          in_full_m, out_full_m, ovr_m, blocked_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic model_reset();
    ptr_m = 16'h0; in_mbx_m = 16'h0; out_mbx_m = 16'h0;
    in_full_m = 1'b0; out_full_m = 1'b0; ovr_m = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_int"},  {15'b0, hif.HPI_INT},  {15'b0, out_full_m});
    chk({tag, "_busy"}, {15'b0, mbx_out_busy}, {15'b0, out_full_m});
    chk({tag, "_vld"},  {15'b0, mbx_in_valid}, {15'b0, in_full_m});
    chk({tag, "_idat"}, mbx_in_data, in_mbx_m);
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d, input bit ack_commit);
    hif.HPI_ADDR = a; host_dat = d; host_en = 1'b1;
    hif.HPI_CS_N = 1'b0; hif.HPI_WR_N = 1'b0;
    cyc(5);
    hif.HPI_CS_N = 1'b1; hif.HPI_WR_N = 1'b1;
    cyc(2);
    if (ack_commit) mbx_in_ack = 1'b1;
    cyc(1);
    mbx_in_ack = 1'b0; host_en = 1'b0;
    cyc(2);
    if (!blocked_m) begin
      case (a)
        2'd0: begin
          mem_m[ptr_m[AW:1]] = d; mem_v[ptr_m[AW:1]] = 1'b1; ptr_m = ptr_m + 16'd2;
        end
        2'd1: begin
          if (in_full_m) ovr_m = 1'b1;
          in_mbx_m = d; in_full_m = 1'b1;
        end
        2'd2: ptr_m = d;
        default: ;
      endcase
      if (ack_commit && a != 2'd1) in_full_m = 1'b0;
    end
  endtask

  task automatic host_read(input logic [1:0] a, input string tag, output logic [15:0] q);
    logic [15:0] exp;
    bit known;
    known = 1'b1;
    case (a)
      2'd0: begin exp = mem_m[ptr_m[AW:1]]; known = mem_v[ptr_m[AW:1]]; end
      2'd1: exp = out_mbx_m;
      2'd2: exp = ptr_m;
      default: exp = {13'b0, ovr_m, in_full_m, out_full_m};
    endcase
    if (blocked_m) begin exp = 16'hFFFF; known = 1'b1; end
    hif.HPI_ADDR = a; hif.HPI_CS_N = 1'b0; hif.HPI_RD_N = 1'b0;
    cyc(3);
    q = hpi_data;
    cyc(2);
    hif.HPI_CS_N = 1'b1; hif.HPI_RD_N = 1'b1;
    cyc(5);
    if (known) chk(tag, q, exp);
    chk({tag, "_rel"}, hpi_data, 16'hFFFF);
    if (!blocked_m) begin
      case (a)
        2'd0: ptr_m = ptr_m + 16'd2;
        2'd1: out_full_m = 1'b0;
        2'd3: ovr_m = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic loc_out(input logic [15:0] d);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    cyc(1);
    mbx_out_wr = 1'b0;
    if (!out_full_m) begin out_mbx_m = d; out_full_m = 1'b1; end
  endtask

  task automatic loc_ack();
    mbx_in_ack = 1'b1;
    cyc(1);
    mbx_in_ack = 1'b0;
    in_full_m = 1'b0;
  endtask

  task automatic loc_read(input logic [AW-1:0] idx, input string tag);
    loc_addr = idx;
    cyc(1);
    if (mem_v[idx]) chk(tag, loc_rdata, mem_m[idx]);
  endtask

  logic [15:0] q;

  initial begin
    Reset = 1'b1; host_en = 1'b0; host_dat = 16'h0;
    hif.HPI_ADDR = 2'd0; hif.HPI_CS_N = 1'b1; hif.HPI_RD_N = 1'b1;
    hif.HPI_WR_N = 1'b1; hif.HPI_RST_N = 1'b1;
    mbx_in_ack = 1'b0; mbx_out_data = 16'h0; mbx_out_wr = 1'b0; loc_addr = '0;
    blocked_m = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) mem_v[i] = 1'b0;
    cyc(3);
    chk("rst_bus", hpi_data, 16'hFFFF);
    chk("rst_loc", loc_rdata, 16'h0000);
    chk_flags("rst");
    Reset = 1'b0;
    cyc(2);
    host_read(2'd2, "rst_ptr", q);  chk("rst_ptr_lit", q, 16'h0000);
    host_read(2'd3, "rst_stat", q); chk("rst_stat_lit", q, 16'h0000);

    // Pointer auto-increment through DATA writes and reads
    host_write(2'd2, 16'h0010, 1'b0);
    host_write(2'd0, 16'hA5A5, 1'b0);
    host_write(2'd0, 16'h5A5A, 1'b0);
    host_write(2'd2, 16'h0010, 1'b0);
    host_read(2'd0, "rd0", q); chk("rd0_lit", q, 16'hA5A5);
    host_read(2'd0, "rd1", q); chk("rd1_lit", q, 16'h5A5A);
    host_read(2'd2, "ptr14", q); chk("ptr14_lit", q, 16'h0014);
    loc_read(12'd8, "loc8");     chk("loc8_lit", loc_rdata, 16'hA5A5);

    // Pointer wrap at the top of the byte address space
    host_write(2'd2, 16'hFFFE, 1'b0);
    host_write(2'd0, 16'h1234, 1'b0);
    host_read(2'd2, "wrap", q);  chk("wrap_lit", q, 16'h0000);
    loc_read(12'(DEPTH - 1), "loc_top"); chk("loc_top_lit", loc_rdata, 16'h1234);

    // Outbound mailbox
    loc_out(16'hBEEF);
    chk("int_rise", {15'b0, hif.HPI_INT}, 16'h0001);
    host_read(2'd3, "stat_out", q); chk("stat_out_lit", q, 16'h0001);
    loc_out(16'h1111);
    host_read(2'd1, "mbx_out", q);  chk("mbx_out_lit", q, 16'hBEEF);
    chk("int_fall", {15'b0, hif.HPI_INT}, 16'h0000);
    chk_flags("out");

    // Inbound mailbox overrun
    host_write(2'd1, 16'h0001, 1'b0);
    host_write(2'd1, 16'h0002, 1'b0);
    chk("in_dat_lit", mbx_in_data, 16'h0002);
    host_read(2'd3, "stat_ovr", q); chk("stat_ovr_lit", q, 16'h0006);
    host_read(2'd3, "stat_clr", q); chk("stat_clr_lit", q, 16'h0002);
    loc_ack();
    chk_flags("ack");

    // Local ack on the same cycle as a host mailbox commit
    host_write(2'd1, 16'h0003, 1'b0);
    host_write(2'd1, 16'h0004, 1'b1);
    chk("coin_vld", {15'b0, mbx_in_valid}, 16'h0001);
    chk("coin_dat", mbx_in_data, 16'h0004);
    host_read(2'd3, "coin_stat", q);
    loc_ack();
    chk_flags("coin");

    // Hard reset in the middle of a read
    host_write(2'd2, 16'h0010, 1'b0);
    loc_out(16'hCAFE);
    hif.HPI_ADDR = 2'd0; hif.HPI_CS_N = 1'b0; hif.HPI_RD_N = 1'b0;
    cyc(5);
    chk("mid_drive", hpi_data, 16'hA5A5);
    #1 Reset = 1'b1;
    #1 chk("mid_rel", hpi_data, 16'hFFFF);
    chk("mid_int", {15'b0, hif.HPI_INT}, 16'h0000);
    hif.HPI_CS_N = 1'b1; hif.HPI_RD_N = 1'b1;
    cyc(2);
    Reset = 1'b0;
    model_reset();
    cyc(2);
    host_read(2'd2, "mid_ptr", q);
    loc_read(12'd8, "mid_mem");

    // Host soft reset keeps memory and blocks access while low
    host_write(2'd2, 16'h0020, 1'b0);
    host_write(2'd0, 16'h7777, 1'b0);
    loc_out(16'h1357);
    host_write(2'd1, 16'h4444, 1'b0);
    hif.HPI_RST_N = 1'b0;
    cyc(4);
    model_reset();
    blocked_m = 1'b1;
    chk_flags("srst");
    host_write(2'd2, 16'h0100, 1'b0);
    host_read(2'd2, "srst_blk", q);
    hif.HPI_RST_N = 1'b1;
    cyc(4);
    blocked_m = 1'b0;
    host_read(2'd2, "srst_ptr", q);
    host_write(2'd2, 16'h0020, 1'b0);
    host_read(2'd0, "srst_mem", q); chk("srst_mem_lit", q, 16'h7777);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: host_write(2'd2, ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                        : 16'($urandom_range(0, 40)), 1'b0);
        1: host_write(2'd0, 16'($urandom), 1'b0);
        2: host_read(2'd0, "r_data", q);
        3: host_read(2'd2, "r_ptr", q);
        4: host_read(2'd3, "r_stat", q);
        5: host_write(2'd1, 16'($urandom), 1'($urandom_range(0, 1)));
        6: host_read(2'd1, "r_mbx", q);
        7: loc_out(16'($urandom));
        8: loc_ack();
        default: loc_read(($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 24))
                                                      : 12'($urandom_range(4088, 4095)), "r_loc");
      endcase
      chk_flags("r");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
